// File: rtl/gpu_stencil_banked_cache_if.sv
// Request/response bundle of the banked stencil store: read port, masked
// write port, clear control and status.
interface gpu_stencil_banked_cache_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              stencil_rd_req_i;
    logic [ADDR_W-1:0] stencil_rd_addr_i;
    logic [DATA_W-1:0] stencil_rd_value_o;
    logic              stencil_rd_valid_o;
    logic              stencil_wr_req_i;
    logic [ADDR_W-1:0] stencil_wr_addr_i;
    logic [DATA_W-1:0] stencil_wr_mask_i;
    logic [DATA_W-1:0] stencil_wr_value_i;
    logic              clear_req_i;
    logic [DATA_W-1:0] clear_value_i;
    logic              busy_o;
    logic              stencil_error_o;

    modport master (
        output stencil_rd_req_i, stencil_rd_addr_i,
        output stencil_wr_req_i, stencil_wr_addr_i, stencil_wr_mask_i, stencil_wr_value_i,
        output clear_req_i, clear_value_i,
        input  stencil_rd_value_o, stencil_rd_valid_o, busy_o, stencil_error_o
    );

    modport slave (
        input  stencil_rd_req_i, stencil_rd_addr_i,
        input  stencil_wr_req_i, stencil_wr_addr_i, stencil_wr_mask_i, stencil_wr_value_i,
        input  clear_req_i, clear_value_i,
        output stencil_rd_value_o, stencil_rd_valid_o, busy_o, stencil_error_o
    );
endinterface

// File: rtl/gpu_stencil_banked_cache.sv
// Banked stencil store: 1-cycle reads, pipelined masked RMW writes with S1
// forwarding, and a clear engine filling every bank in parallel.
module gpu_stencil_banked_cache #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int BANK_BITS = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    gpu_stencil_banked_cache_if.slave     bus
);
    localparam int BANKS = 1 << BANK_BITS;
    localparam int IDX_W = ADDR_W - BANK_BITS;
    localparam int WORDS = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return {addr[6 +: BANK_BITS-1], addr[0]};
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1 : 5+BANK_BITS], addr[5:1]};
    endfunction

    logic [DATA_W-1:0]    mem_q [BANKS][WORDS];

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [IDX_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]    clr_value_q, clr_value_d;

    logic                 s1_vld_q;
    logic [BANK_BITS-1:0] s1_bank_q;
    logic [IDX_W-1:0]     s1_idx_q;
    logic [DATA_W-1:0]    s1_old_q, s1_mask_q, s1_value_q;
    logic                 rd_valid_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic                 error_q;

    logic                 rd_acc_s, wr_acc_s;
    logic [BANK_BITS-1:0] rd_bank_s, wr_bank_s;
    logic [IDX_W-1:0]     rd_idx_s, wr_idx_s;
    logic [DATA_W-1:0]    merged_s, wr_old_s, rd_word_s;

    // Address decode, S1 merge and forwarding muxes for both ports
    always_comb begin
        rd_acc_s  = bus.stencil_rd_req_i & ~busy_q;
        wr_acc_s  = bus.stencil_wr_req_i & ~busy_q;
        rd_bank_s = bank_of(bus.stencil_rd_addr_i);
        rd_idx_s  = index_of(bus.stencil_rd_addr_i);
        wr_bank_s = bank_of(bus.stencil_wr_addr_i);
        wr_idx_s  = index_of(bus.stencil_wr_addr_i);
        merged_s  = (s1_value_q & s1_mask_q) | (s1_old_q & ~s1_mask_q);
        // The S1 word is not in RAM yet, so both ports must bypass it
        if (s1_vld_q && (s1_bank_q == wr_bank_s) && (s1_idx_q == wr_idx_s)) begin
            wr_old_s = merged_s;
        end else begin
            wr_old_s = mem_q[wr_bank_s][wr_idx_s];
        end
        if (s1_vld_q && (s1_bank_q == rd_bank_s) && (s1_idx_q == rd_idx_s)) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = mem_q[rd_bank_s][rd_idx_s];
        end
    end

    // Clear FSM next-state logic
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_value_d = clr_value_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req_i) begin
                    state_d     = ST_DRAIN;
                    clr_value_d = bus.clear_value_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {IDX_W{1'b0}};
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Clear FSM state, counter and fill value registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            clr_cnt_q   <= {IDX_W{1'b0}};
            clr_value_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_value_q <= clr_value_d;
        end
    end

    // Write pipeline stage S1, read output register and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q   <= 1'b0;
            s1_bank_q  <= {BANK_BITS{1'b0}};
            s1_idx_q   <= {IDX_W{1'b0}};
            s1_old_q   <= {DATA_W{1'b0}};
            s1_mask_q  <= {DATA_W{1'b0}};
            s1_value_q <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            error_q    <= 1'b0;
        end else begin
            s1_vld_q   <= wr_acc_s;
            rd_valid_q <= rd_acc_s;
            error_q    <= error_q | (busy_q & (bus.stencil_rd_req_i | bus.stencil_wr_req_i));
            if (wr_acc_s) begin
                s1_bank_q  <= wr_bank_s;
                s1_idx_q   <= wr_idx_s;
                s1_old_q   <= wr_old_s;
                s1_mask_q  <= bus.stencil_wr_mask_i;
                s1_value_q <= bus.stencil_wr_value_i;
            end
            if (rd_acc_s) begin
                rd_data_q <= rd_word_s;
            end
        end
    end

    // Bank RAM write port: clear fill in all banks, otherwise the S1 commit
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                for (int b = 0; b < BANKS; b++) begin
                    mem_q[b][clr_cnt_q] <= clr_value_q;
                end
            end else if (s1_vld_q) begin
                mem_q[s1_bank_q][s1_idx_q] <= merged_s;
            end
        end
    end

    assign bus.stencil_rd_value_o = rd_data_q;
    assign bus.stencil_rd_valid_o = rd_valid_q;
    assign bus.busy_o             = busy_q;
    assign bus.stencil_error_o    = error_q;
endmodule
